// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding,
// default geometry of the RV32I register file and the checksum beat index.
`timescale 1ns/1ps
package reg_dump_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_ADDR_W   = 5;

  // Index reported on the trailing checksum beat (one past the last register)
  localparam int CHECKSUM_INDEX = DEF_NUM_REGS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready beat channel from the dump reader to the debug/UART bridge.
// The master drives the beat; the slave answers with out_ready.
`timescale 1ns/1ps
interface reg_dump_reader_if
  import reg_dump_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic [ADDR_W:0]   out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Debug read-out engine for the RV32I register file.
// On dump_start it raises halt_req, walks every register index through the
// dedicated read port and streams each value out as one valid/ready beat.
// Optional feature macro: REG_DUMP_CHECKSUM_EN -- appends a trailing beat
// carrying the XOR of all register values; that beat then carries out_last.
`timescale 1ns/1ps
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int XLEN     = DEF_XLEN,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dump_start,
  input  logic                 dump_abort,
  output logic                 halt_req,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [XLEN-1:0]      rd_data,
  reg_dump_reader_if.master    out_if,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0]   CSUM_IDX = (ADDR_W + 1)'(NUM_REGS);
`endif

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic                out_valid_q;
  logic [XLEN-1:0]     out_data_q;
  logic [ADDR_W:0]     out_index_q;
  logic                out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [XLEN-1:0]     csum;
`endif

  // Walk FSM: READ presents idx on the read port and captures the value into
  // the output holding register; SEND holds that beat until the sink takes it.
  // The index is tested for the last register before it is incremented, so it
  // never wraps. Abort wins over a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      rd_addr     <= '0;
      halt_req    <= 1'b0;
      done        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && dump_abort) begin
        state       <= IDLE;
        idx         <= '0;
        rd_addr     <= '0;
        halt_req    <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (dump_start) begin
              state    <= READ;
              idx      <= '0;
              rd_addr  <= '0;
              halt_req <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
              csum     <= '0;
`endif
            end
          end
          READ: begin
            out_data_q  <= rd_data;
            out_index_q <= {1'b0, idx};
`ifdef REG_DUMP_CHECKSUM_EN
            out_last_q  <= 1'b0;
            csum        <= csum ^ rd_data;
`else
            out_last_q  <= (idx == LAST_IDX);
`endif
            out_valid_q <= 1'b1;
            state       <= SEND;
          end
          SEND: begin
            if (out_if.out_ready) begin
              if (out_last_q) begin
                out_valid_q <= 1'b0;
                done        <= 1'b1;
                state       <= DONE;
              end
`ifdef REG_DUMP_CHECKSUM_EN
              else if (idx == LAST_IDX) begin
                out_data_q  <= csum;
                out_index_q <= CSUM_IDX;
                out_last_q  <= 1'b1;
              end
`endif
              else begin
                out_valid_q <= 1'b0;
                idx         <= idx + 1'b1;
                rd_addr     <= idx + 1'b1;
                state       <= READ;
              end
            end
          end
          DONE: begin
            state    <= IDLE;
            halt_req <= 1'b0;
            idx      <= '0;
            rd_addr  <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Drive the beat channel straight from the holding register
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_index = out_index_q;
  assign out_if.out_last  = out_last_q;

  // Busy mirrors the halt request seen by the core
  assign busy = halt_req;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a table of dump scenarios is run
// in a loop; expected beats are queued when a dump is launched and popped on
// every handshake. Also honours REG_DUMP_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  localparam int NR = DEF_NUM_REGS;
  localparam int XW = DEF_XLEN;
  localparam int AW = DEF_ADDR_W;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif
  localparam int NBEATS = NR + CKS;

  logic          clk = 1'b0;
  logic          rst;
  logic          dump_start;
  logic          dump_abort;
  logic          halt_req;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [XW-1:0] rd_data;
  logic [XW-1:0] regs [NR];

  reg_dump_reader_if #(.XLEN(XW), .ADDR_W(AW)) out_if ();

  // Register file model: combinational read
  assign rd_data = regs[rd_addr];

  reg_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_abort (dump_abort),
    .halt_req   (halt_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_if     (out_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0]   index;
    logic [XW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int pattern;
    int stall_beat;
    int stall_len;
    int abort_beat;
    int rst_beat;
    int start_beat;
  } vec_t;

  beat_t sbq [$];
  vec_t  vecs [7];
  int    total = 0;
  int    bad   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_halt_req"},  64'(halt_req), 64'd0);
    checkOutput({tag, "_busy"},      64'(busy), 64'd0);
    checkOutput({tag, "_done"},      64'(done), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_if.out_valid), 64'd0);
    checkOutput({tag, "_out_data"},  64'(out_if.out_data), 64'd0);
    checkOutput({tag, "_out_index"}, 64'(out_if.out_index), 64'd0);
    checkOutput({tag, "_out_last"},  64'(out_if.out_last), 64'd0);
    checkOutput({tag, "_rd_addr"},   64'(rd_addr), 64'd0);
  endtask

  task automatic loadPattern(input int p);
    for (int i = 0; i < NR; i++) regs[i] = '0;
    case (p)
      0: begin
        regs[1]  = 32'h11111111;
        regs[31] = 32'hDEADBEEF;
      end
      1: begin
        regs[1]  = 32'h11111111;
        regs[7]  = 32'hA5A5A5A5;
        regs[31] = 32'hDEADBEEF;
      end
      2: begin
        regs[1] = 32'h0000FFFF;
        regs[2] = 32'hFFFF0000;
      end
      default: begin
        for (int i = 1; i < NR; i++) regs[i] = $urandom;
      end
    endcase
  endtask

  task automatic pushExpected();
    beat_t         b;
    logic [XW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NR; i++) begin
      b.index = (AW + 1)'(i);
      b.data  = regs[i];
      b.last  = (CKS == 0) && (i == NR - 1);
      sbq.push_back(b);
      acc = acc ^ regs[i];
    end
    if (CKS != 0) begin
      b.index = (AW + 1)'(CHECKSUM_INDEX);
      b.data  = acc;
      b.last  = 1'b1;
      sbq.push_back(b);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int    exp_done;
    int    ev_n;
    int    end_n;
    int    done_cyc;
    int    done_cnt;
    int    popped;
    int    remaining;
    bit    prev_hold;
    beat_t prev;
    beat_t want;

    loadPattern(v.pattern);
    pushExpected();
    exp_done  = 2 * NR + 2 + CKS + v.stall_len;
    ev_n      = -10;
    remaining = 0;
    if (v.abort_beat >= 0) begin
      ev_n      = 3 + 2 * v.abort_beat;
      remaining = NBEATS - v.abort_beat;
    end else if (v.rst_beat >= 0) begin
      ev_n      = 3 + 2 * v.rst_beat;
      remaining = NBEATS - v.rst_beat;
    end
    end_n     = (ev_n > 0) ? ev_n + 6 : exp_done + 2;
    done_cyc  = 0;
    done_cnt  = 0;
    popped    = 0;
    prev_hold = 1'b0;
    prev      = '{index: '0, data: '0, last: 1'b0};

    for (int n = 1; n <= end_n; n++) begin
      @(posedge clk);
      #1;
      dump_start = (n == 1) ||
                   (v.start_beat >= 0 && (n == 3 + 2 * v.start_beat || n == 4 + 2 * v.start_beat));
      out_if.out_ready = !(v.stall_beat >= 0 && n >= 3 + 2 * v.stall_beat &&
                           n < 3 + 2 * v.stall_beat + v.stall_len);
      dump_abort = (v.abort_beat >= 0 && n == ev_n);
      rst        = (v.rst_beat >= 0 && n == ev_n);
      @(negedge clk);

      if (prev_hold) begin
        checkOutput("hold_valid", 64'(out_if.out_valid), 64'd1);
        checkOutput("hold_data",  64'(out_if.out_data), 64'(prev.data));
        checkOutput("hold_index", 64'(out_if.out_index), 64'(prev.index));
        checkOutput("hold_last",  64'(out_if.out_last), 64'(prev.last));
      end
      if (n == 2) begin
        checkOutput("valid_cycle2", 64'(out_if.out_valid), 64'd0);
        checkOutput("halt_cycle2",  64'(halt_req), 64'd1);
      end
      if (n == 3) checkOutput("valid_cycle3", 64'(out_if.out_valid), 64'd1);
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (v.abort_beat >= 0 && n == ev_n + 1) begin
        checkOutput("abort_halt_req",  64'(halt_req), 64'd0);
        checkOutput("abort_busy",      64'(busy), 64'd0);
        checkOutput("abort_out_valid", 64'(out_if.out_valid), 64'd0);
      end
      if (v.rst_beat >= 0 && n == ev_n + 1) checkAllZero("midrst");
      if (ev_n < 0 && n == exp_done + 1) begin
        checkOutput("idle_halt_req", 64'(halt_req), 64'd0);
        checkOutput("idle_busy",     64'(busy), 64'd0);
      end

      if (out_if.out_valid && out_if.out_ready && !dump_abort && !rst) begin
        popped++;
        if (sbq.size() == 0) begin
          checkOutput("beat_count", 64'(popped), 64'(NBEATS));
        end else begin
          want = sbq.pop_front();
          checkOutput("beat_index", 64'(out_if.out_index), 64'(want.index));
          checkOutput("beat_data",  64'(out_if.out_data), 64'(want.data));
          checkOutput("beat_last",  64'(out_if.out_last), 64'(want.last));
        end
      end

      prev_hold  = out_if.out_valid && !out_if.out_ready && !dump_abort && !rst;
      prev.index = out_if.out_index;
      prev.data  = out_if.out_data;
      prev.last  = out_if.out_last;
    end

    dump_start       = 1'b0;
    dump_abort       = 1'b0;
    rst              = 1'b0;
    out_if.out_ready = 1'b1;

    checkOutput("done_count", 64'(done_cnt), (ev_n > 0) ? 64'd0 : 64'd1);
    if (ev_n < 0) checkOutput("done_cycle", 64'(done_cyc), 64'(exp_done));
    checkOutput("beats_left", 64'(sbq.size()), 64'(remaining));
    sbq.delete();
  endtask

  initial begin
    // pattern, stall_beat, stall_len, abort_beat, rst_beat, start_beat
    vecs[0] = '{0, -1, 0, -1, -1, -1};
    vecs[1] = '{1,  7, 5, -1, -1, -1};
    vecs[2] = '{1, -1, 0, 10, -1, -1};
    vecs[3] = '{0, -1, 0, -1, -1,  3};
    vecs[4] = '{0, -1, 0, -1, 20, -1};
    vecs[5] = '{2, -1, 0, -1, -1, -1};
    vecs[6] = '{3,  0, 3, -1, -1, -1};

    rst              = 1'b1;
    dump_start       = 1'b0;
    dump_abort       = 1'b0;
    out_if.out_ready = 1'b1;
    for (int i = 0; i < NR; i++) regs[i] = '0;

    // Power-on reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Start pulse while held in reset must not launch a dump
    @(posedge clk);
    #1;
    rst        = 1'b1;
    dump_start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    dump_start = 1'b0;
    @(negedge clk);
    checkOutput("start_in_reset_halt", 64'(halt_req), 64'd0);

    for (int k = 0; k < 7; k++) begin
      $display("[TB] scenario %0d", k);
      applyStimulus(vecs[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug read-out engine for the RV32I register file; it is the reading end of the register file's read-port interface.
- On a start request it requests a core halt, then walks register indices 0..NUM_REGS-1 through a dedicated read address/data port.
- It streams each value out over a valid/ready channel to the debug/UART bridge.
- Sits beside the single-cycle core; the read port is muxed onto the register file's src2 read path while halt_req is high.

Parameters:
- NUM_REGS, 32, number of architectural registers walked.
- XLEN, 32, register data width.
- ADDR_W, 5, register index width (clog2(NUM_REGS)).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- dump_start  in  1  request a dump; sampled only in IDLE.
- dump_abort  in  1  terminate the dump in progress.
- halt_req  out  1  asks the core to freeze register writes; high in every non-IDLE state.
- rd_addr  out  ADDR_W  register read index driven to the register file.
- rd_data  in  XLEN  combinational read value for rd_addr.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_data  out  XLEN  beat payload.
- out_index  out  ADDR_W+1  register index of the beat (NUM_REGS for the checksum beat).
- out_last  out  1  final beat of the dump.
- busy  out  1  equals halt_req.
- done  out  1  one-cycle pulse after a completed (not aborted) dump.

Behaviour:
- Reset: state=IDLE, idx=0; all outputs 0, including rd_addr, out_data and out_index. Reset mid-dump abandons it with no done pulse.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE -> READ when dump_start=1; idx<=0.
- READ:
  - rd_addr=idx.
  - Capture rd_data into out_data and idx into out_index.
  - out_last <= (idx==NUM_REGS-1) when the checksum feature is absent.
  - Next state is SEND.
- SEND:
  - out_valid=1.
  - out_data, out_index and out_last stay stable until out_ready=1.
  - On handshake: if last -> DONE, else idx<=idx+1 and go to READ.
- DONE: done=1 for exactly one cycle, then IDLE. halt_req drops in the IDLE cycle.
- Timing:
  - First out_valid 2 cycles after the cycle in which dump_start is sampled.
  - Throughput is one beat per 2 cycles with out_ready held high.
  - A full dump with no checksum is 32 beats, 66 cycles from start to done.
- rd_addr holds its last value outside READ. It returns to 0 only on reset or entry to IDLE.
- Register x0 is read like any other register; it reads 0 from the register file.
- dump_start while not IDLE: ignored, not queued.
- dump_abort in any non-IDLE state: IDLE next cycle, out_valid=0, no done pulse. Abort takes priority over a simultaneous handshake; that beat counts as not transferred.
- out_valid never deasserts without a handshake, except on abort or reset.
- idx never wraps; the index is compared before incrementing.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Enabled:
  - A running XOR accumulator of every captured word is added; it clears on IDLE->READ.
  - After the handshake of index NUM_REGS-1, the FSM enters SEND once more with out_data=checksum, out_index=NUM_REGS, out_last=1.
  - A full dump is 33 beats, and done follows the checksum handshake.
  - Register beats all have out_last=0.
- Disabled: no accumulator, 32 beats, out_last on index NUM_REGS-1.

Decomposition:
- Shared package reg_dump_pkg holds:
  - State encoding constants (IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3).
  - NUM_REGS/XLEN defaults.
  - CHECKSUM_INDEX = NUM_REGS.
- Single module; no sub-module needed.
- The output holding register with its valid/ready hold logic may be factored as reg_dump_out_stage if reused by the debug bridge.

Test Plan:
- Basic dump: preload x1=0x11111111, x31=0xDEADBEEF, rest zero, out_ready=1, pulse dump_start. Expect:
  - 32 beats in index order 0..31; x0 beat data 0; beat 31 data 0xDEADBEEF with out_last=1.
  - done pulse at cycle 66.
- Backpressure: hold out_ready=0 for 5 cycles at beat 7 (x7=0xA5A5A5A5). Expect out_data, out_index and out_valid stable through the stall, beat order unchanged, and the total extended by 5 cycles.
- Abort: assert dump_abort together with out_ready at beat 10. Expect IDLE next cycle, halt_req=0, no done pulse. A fresh dump_start restarts at index 0.
- Ignored start and reset mid-dump:
  - dump_start pulses during beat 3 have no effect.
  - rst at beat 20 clears all outputs the next cycle, with no done pulse.
- Checksum (REG_DUMP_CHECKSUM_EN): x1=0x0000FFFF, x2=0xFFFF0000, rest 0. Expect a 33rd beat with out_index=32, out_data=0xFFFFFFFF, out_last=1. Beat 31 has out_last=0.
